// File: rtl/axi_store_buffer_pkg.sv
// Shared definitions for the AXI posted-write store buffer.
//   - FSM state encodings (IDLE / SEND / RESP)
//   - store entry layout and its packed length
//   - constant AXI write-channel field values
// Optional feature macro used by the top: STBUF_BRESP_ERR_EN (sticky bus_err).
package axi_store_buffer_pkg;

    localparam int STBUF_ADDR_W    = 32;
    localparam int STBUF_SIZE_W    = 2;
    localparam int STBUF_STRB_W    = 4;
    localparam int STBUF_DATA_W    = 32;
    // Word address (byte address without the two lane bits) used by the conflict check.
    localparam int STBUF_WADDR_W   = STBUF_ADDR_W - 2;
    localparam int STBUF_ENTRY_LEN = 70;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RESP = 2'd2
    } stbuf_state_e;

    // addr is the most significant field; the FIFO relies on this to slice the
    // word address straight out of raw storage.
    typedef struct packed {
        logic [STBUF_ADDR_W-1:0] addr;
        logic [STBUF_SIZE_W-1:0] size;
        logic [STBUF_STRB_W-1:0] wstrb;
        logic [STBUF_DATA_W-1:0] wdata;
    } stbuf_entry_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

    // Store size 0/1/2 maps directly onto AXI awsize 1/2/4 bytes.
    function automatic logic [2:0] axi_size_from(input logic [STBUF_SIZE_W-1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/stbuf_fifo.sv
// Store buffer FIFO: DEPTH entries of stbuf_entry_t.
// Ports:
//   aclk, aresetn      clock, synchronous active-low reset
//   push, push_entry   write one entry (caller guarantees ~full)
//   pop                retire the head entry (caller guarantees ~empty)
//   head_entry         entry at the read pointer, combinational
//   full, empty        derived from a separate occupancy count
//   entry_valid        per-slot valid bits, for the conflict compare
//   entry_waddr        per-slot word address (addr[31:2]), for the conflict compare
module stbuf_fifo
    import axi_store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     push,
    input  stbuf_entry_t             push_entry,
    input  logic                     pop,
    output stbuf_entry_t             head_entry,
    output logic                     full,
    output logic                     empty,
    output logic [DEPTH-1:0]         entry_valid,
    output logic [STBUF_WADDR_W-1:0] entry_waddr [DEPTH]
);

    localparam int PW = $clog2(DEPTH);

    logic [STBUF_ENTRY_LEN-1:0] mem [DEPTH];
    logic [PW-1:0]              wptr;
    logic [PW-1:0]              rptr;
    logic [PW:0]                count;
    logic [DEPTH-1:0]           valid_q;

    // Storage is not reset; the valid bits and count say what is meaningful.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wptr] <= push_entry;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                wptr          <= wptr + PW'(1);
                valid_q[wptr] <= 1'b1;
            end
            if (pop) begin
                rptr          <= rptr + PW'(1);
                valid_q[rptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_entry  = stbuf_entry_t'(mem[rptr]);
    assign full        = (count == (PW+1)'(DEPTH));
    assign empty       = (count == '0);
    assign entry_valid = valid_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_waddr[i] = mem[i][STBUF_ENTRY_LEN-1 -: STBUF_WADDR_W];
        end
    end

endmodule

// File: rtl/axi_store_buffer.sv
// Posted-write store buffer between the data-store request path and the AXI
// write channels. Stores are accepted in one cycle into a DEPTH-entry FIFO and
// drained as single-beat AXI writes, one outstanding at a time. A combinational
// word-address compare lets the load path stall a read that would overtake a
// pending store.
// Ports:
//   aclk, aresetn                      clock, synchronous active-low reset
//   st_req/st_addr/st_size/st_wstrb/st_wdata, st_addr_ok   store request / accept
//   chk_addr, chk_conflict             load address conflict check
//   buf_empty                          nothing buffered and nothing in flight
//   aw*, w*, b*                        AXI write address / data / response channels
//   bus_err (only with STBUF_BRESP_ERR_EN) sticky error on a non-OKAY bresp
// Configuration macro: STBUF_BRESP_ERR_EN.
//
// Handshake semantics: a transfer on any channel happens in a cycle where both
// valid and ready are high at the posedge. Once raised, awvalid/wvalid stay high
// with awaddr/wdata/wstrb stable until their own transfer; st_addr_ok is a ready
// that does not depend on st_req.
module axi_store_buffer
    import axi_store_buffer_pkg::*;
#(
    parameter int         DEPTH  = 4,
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        st_req,
    input  logic [31:0] st_addr,
    input  logic [1:0]  st_size,
    input  logic [3:0]  st_wstrb,
    input  logic [31:0] st_wdata,
    output logic        st_addr_ok,
    input  logic [31:0] chk_addr,
    output logic        chk_conflict,
    output logic        buf_empty,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
`ifdef STBUF_BRESP_ERR_EN
    ,
    output logic        bus_err
`endif
);

    stbuf_entry_t             push_entry;
    stbuf_entry_t             head;
    logic                     push;
    logic                     pop;
    logic                     full;
    logic                     empty;
    logic [DEPTH-1:0]         entry_valid;
    logic [STBUF_WADDR_W-1:0] entry_waddr [DEPTH];

    stbuf_state_e state, state_n;
    logic         aw_done, aw_done_n;
    logic         w_done, w_done_n;

    // No bypass: a pop only frees space from the next cycle because full is
    // derived from the registered count.
    assign st_addr_ok = ~full;
    assign push       = st_req & ~full;
    assign push_entry = '{addr: st_addr, size: st_size, wstrb: st_wstrb, wdata: st_wdata};

    stbuf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .head_entry  (head),
        .full        (full),
        .empty       (empty),
        .entry_valid (entry_valid),
        .entry_waddr (entry_waddr)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state   <= ST_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_n;
            aw_done <= aw_done_n;
            w_done  <= w_done_n;
        end
    end

    // Valids are derived from state and the done flags, so each drops the
    // cycle after its own handshake and never re-asserts within one store.
    always_comb begin
        state_n   = state;
        aw_done_n = aw_done;
        w_done_n  = w_done;
        pop       = 1'b0;
        awvalid   = (state == ST_SEND) & ~aw_done;
        wvalid    = (state == ST_SEND) & ~w_done;
        bready    = (state == ST_RESP);
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    state_n   = ST_SEND;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                end
            end
            ST_SEND: begin
                aw_done_n = aw_done | (awvalid & awready);
                w_done_n  = w_done  | (wvalid & wready);
                if (aw_done_n && w_done_n) begin
                    state_n = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bvalid) begin
                    pop     = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign awid    = AXI_ID;
    assign awaddr  = head.addr;
    assign awlen   = AXI_LEN_SINGLE;
    assign awsize  = axi_size_from(head.size);
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign wid     = AXI_ID;
    assign wdata   = head.wdata;
    assign wstrb   = head.wstrb;
    assign wlast   = 1'b1;

    // The head stays valid (and thus conflicting) until its b handshake pops it.
    always_comb begin
        chk_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_waddr[i] == chk_addr[31:2])) begin
                chk_conflict = 1'b1;
            end
        end
    end

    assign buf_empty = empty & (state == ST_IDLE);

`ifdef STBUF_BRESP_ERR_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            bus_err <= 1'b0;
        end else if (bvalid && bready && (bresp != 2'b00)) begin
            bus_err <= 1'b1;
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{bid, chk_addr[1:0]};
`else
    logic unused_inputs;
    assign unused_inputs = ^{bid, bresp, chk_addr[1:0]};
`endif

endmodule

// File: tb/tb_axi_store_buffer.sv
// Directed testbench for axi_store_buffer (DEPTH = 4, AXI_ID = 1).
// Inputs are driven 2 time units after the rising edge and outputs are checked
// 1 unit after any input change, well away from the active edge.
// Build with STBUF_BRESP_ERR_EN defined to also exercise bus_err.
module tb_axi_store_buffer;

  logic        aclk;
  logic        aresetn;
  logic        st_req;
  logic [31:0] st_addr;
  logic [1:0]  st_size;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic        st_addr_ok;
  logic [31:0] chk_addr;
  logic        chk_conflict;
  logic        buf_empty;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
`ifdef STBUF_BRESP_ERR_EN
  logic        bus_err;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr;

  axi_store_buffer dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .st_req       (st_req),
    .st_addr      (st_addr),
    .st_size      (st_size),
    .st_wstrb     (st_wstrb),
    .st_wdata     (st_wdata),
    .st_addr_ok   (st_addr_ok),
    .chk_addr     (chk_addr),
    .chk_conflict (chk_conflict),
    .buf_empty    (buf_empty),
    .awid         (awid),
    .awaddr       (awaddr),
    .awlen        (awlen),
    .awsize       (awsize),
    .awburst      (awburst),
    .awlock       (awlock),
    .awcache      (awcache),
    .awprot       (awprot),
    .awvalid      (awvalid),
    .awready      (awready),
    .wid          (wid),
    .wdata        (wdata),
    .wstrb        (wstrb),
    .wlast        (wlast),
    .wvalid       (wvalid),
    .wready       (wready),
    .bid          (bid),
    .bresp        (bresp),
    .bvalid       (bvalid),
    .bready       (bready)
`ifdef STBUF_BRESP_ERR_EN
    ,
    .bus_err      (bus_err)
`endif
  );

  // Clock / watchdog
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge aclk);
    #2;
  endtask

  task automatic check(input string tag, input logic ok,
                       input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    aresetn  = 1'b0;
    st_req   = 1'b0;
    st_addr  = '0;
    st_size  = 2'd2;
    st_wstrb = 4'hF;
    st_wdata = '0;
    chk_addr = '0;
    awready  = 1'b0;
    wready   = 1'b0;
    bid      = 4'd1;
    bresp    = 2'b00;
    bvalid   = 1'b0;
    repeat (2) cyc();
    #1;

    // Reset state
    check("rst_addr_ok", st_addr_ok === 1'b1, st_addr_ok, 1'b1);
    check("rst_buf_empty", buf_empty === 1'b1, buf_empty, 1'b1);
    check("rst_awvalid", awvalid === 1'b0, awvalid, 1'b0);
    check("rst_wvalid", wvalid === 1'b0, wvalid, 1'b0);
    check("rst_bready", bready === 1'b0, bready, 1'b0);
    check("rst_conflict", chk_conflict === 1'b0, chk_conflict, 1'b0);
    aresetn = 1'b1;
    cyc();

    // Single store, all slave readies high
    awready  = 1'b1;
    wready   = 1'b1;
    bvalid   = 1'b1;
    st_req   = 1'b1;
    st_addr  = 32'h1C00_0104;
    st_size  = 2'd2;
    st_wstrb = 4'hF;
    st_wdata = 32'hDEAD_BEEF;
    #1;
    check("t1_addr_ok", st_addr_ok === 1'b1, st_addr_ok, 1'b1);
    cyc();
    st_req = 1'b0;
    #1;
    check("t1_not_empty", buf_empty === 1'b0, buf_empty, 1'b0);
    check("t1_idle_awvalid", awvalid === 1'b0, awvalid, 1'b0);
    cyc();
    check("t1_awvalid", awvalid === 1'b1, awvalid, 1'b1);
    check("t1_wvalid", wvalid === 1'b1, wvalid, 1'b1);
    check("t1_awaddr", awaddr === 32'h1C00_0104, awaddr, 32'h1C00_0104);
    check("t1_awsize", awsize === 3'd2, awsize, 3'd2);
    check("t1_wdata", wdata === 32'hDEAD_BEEF, wdata, 32'hDEAD_BEEF);
    check("t1_wstrb", wstrb === 4'hF, wstrb, 4'hF);
    check("t1_wlast", wlast === 1'b1, wlast, 1'b1);
    check("t1_awlen", awlen === 8'd0, awlen, 8'd0);
    check("t1_awburst", awburst === 2'b01, awburst, 2'b01);
    check("t1_awid", awid === 4'd1, awid, 4'd1);
    check("t1_wid", wid === 4'd1, wid, 4'd1);
    cyc();
    check("t1_bready", bready === 1'b1, bready, 1'b1);
    check("t1_resp_awvalid", awvalid === 1'b0, awvalid, 1'b0);
    check("t1_resp_wvalid", wvalid === 1'b0, wvalid, 1'b0);
    check("t1_resp_not_empty", buf_empty === 1'b0, buf_empty, 1'b0);
    cyc();
    check("t1_empty_after3", buf_empty === 1'b1, buf_empty, 1'b1);
    check("t1_bready_low", bready === 1'b0, bready, 1'b0);

    // Fill all four entries while the slave stalls
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st_req   = 1'b1;
      st_addr  = 32'h100 * (i + 1) + 32'(4 * i);
      st_wdata = 32'hA000_0000 + 32'(i);
      #1;
      check("t2_addr_ok_fill", st_addr_ok === 1'b1, st_addr_ok, 1'b1);
      exp_q.push_back(st_addr);
      cyc();
    end
    st_addr  = 32'h510;
    st_wdata = 32'hA000_0004;
    #1;
    check("t2_full", st_addr_ok === 1'b0, st_addr_ok, 1'b0);
    check("t2_head_awvalid", awvalid === 1'b1, awvalid, 1'b1);
    exp_addr = exp_q.pop_front();
    check("t2_order_0", awaddr === exp_addr, awaddr, exp_addr);
    awready = 1'b1;
    wready  = 1'b1;
    cyc();
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b1;
    #1;
    check("t2_resp_bready", bready === 1'b1, bready, 1'b1);
    check("t2_still_full", st_addr_ok === 1'b0, st_addr_ok, 1'b0);
    cyc();
    check("t2_space_after_b", st_addr_ok === 1'b1, st_addr_ok, 1'b1);
    exp_q.push_back(st_addr);
    cyc();
    st_req = 1'b0;
    #1;
    check("t2_refull", st_addr_ok === 1'b0, st_addr_ok, 1'b0);
    awready = 1'b1;
    wready  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t2_drain_awvalid", awvalid === 1'b1, awvalid, 1'b1);
      exp_addr = exp_q.pop_front();
      check("t2_order", awaddr === exp_addr, awaddr, exp_addr);
      repeat (3) cyc();
    end
    #1;
    check("t2_drained", buf_empty === 1'b1, buf_empty, 1'b1);

    // wready accepted three cycles before awready
    awready  = 1'b0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    st_req   = 1'b1;
    st_addr  = 32'h600;
    st_wdata = 32'h1234_5678;
    cyc();
    st_req = 1'b0;
    cyc();
    wready = 1'b1;
    #1;
    check("t3_c0_wvalid", wvalid === 1'b1, wvalid, 1'b1);
    check("t3_c0_awvalid", awvalid === 1'b1, awvalid, 1'b1);
    cyc();
    wready = 1'b0;
    #1;
    check("t3_c1_wvalid", wvalid === 1'b0, wvalid, 1'b0);
    check("t3_c1_awvalid", awvalid === 1'b1, awvalid, 1'b1);
    check("t3_c1_wdata", wdata === 32'h1234_5678, wdata, 32'h1234_5678);
    cyc();
    check("t3_c2_bready", bready === 1'b0, bready, 1'b0);
    check("t3_c2_awvalid", awvalid === 1'b1, awvalid, 1'b1);
    cyc();
    awready = 1'b1;
    #1;
    check("t3_c3_awvalid", awvalid === 1'b1, awvalid, 1'b1);
    check("t3_c3_wdata", wdata === 32'h1234_5678, wdata, 32'h1234_5678);
    cyc();
    awready = 1'b0;
    #1;
    check("t3_c4_bready", bready === 1'b1, bready, 1'b1);
    check("t3_c4_awvalid", awvalid === 1'b0, awvalid, 1'b0);
    check("t3_c4_wdata", wdata === 32'h1234_5678, wdata, 32'h1234_5678);
    bvalid = 1'b1;
    cyc();
    bvalid = 1'b0;
    #1;
    check("t3_empty", buf_empty === 1'b1, buf_empty, 1'b1);

    // Conflict check at word granularity
    chk_addr = 32'h803;
    st_req   = 1'b1;
    st_addr  = 32'h800;
    st_wdata = 32'h0000_0800;
    #1;
    check("t4_same_cycle_invisible", chk_conflict === 1'b0, chk_conflict, 1'b0);
    cyc();
    st_req = 1'b0;
    #1;
    check("t4_hit_803", chk_conflict === 1'b1, chk_conflict, 1'b1);
    chk_addr = 32'h804;
    #1;
    check("t4_miss_804", chk_conflict === 1'b0, chk_conflict, 1'b0);
    chk_addr = 32'h803;
    cyc();
    awready = 1'b1;
    wready  = 1'b1;
    cyc();
    awready = 1'b0;
    wready  = 1'b0;
    #1;
    check("t4_resp_bready", bready === 1'b1, bready, 1'b1);
    check("t4_hit_until_b", chk_conflict === 1'b1, chk_conflict, 1'b1);
    bvalid = 1'b1;
    cyc();
    bvalid = 1'b0;
    #1;
    check("t4_clear_after_b", chk_conflict === 1'b0, chk_conflict, 1'b0);
    check("t4_empty", buf_empty === 1'b1, buf_empty, 1'b1);

    // Reset while sending with two entries buffered
    st_req  = 1'b1;
    st_addr = 32'hA00;
    cyc();
    st_addr = 32'hA04;
    cyc();
    st_req   = 1'b0;
    chk_addr = 32'hA04;
    #1;
    check("t5_send_awvalid", awvalid === 1'b1, awvalid, 1'b1);
    check("t5_pre_conflict", chk_conflict === 1'b1, chk_conflict, 1'b1);
    check("t5_pre_not_empty", buf_empty === 1'b0, buf_empty, 1'b0);
    aresetn = 1'b0;
    cyc();
    aresetn = 1'b1;
    #1;
    check("t5_awvalid", awvalid === 1'b0, awvalid, 1'b0);
    check("t5_wvalid", wvalid === 1'b0, wvalid, 1'b0);
    check("t5_buf_empty", buf_empty === 1'b1, buf_empty, 1'b1);
    check("t5_conflict", chk_conflict === 1'b0, chk_conflict, 1'b0);
    check("t5_addr_ok", st_addr_ok === 1'b1, st_addr_ok, 1'b1);
    cyc();
    check("t5_stays_idle", awvalid === 1'b0, awvalid, 1'b0);

`ifdef STBUF_BRESP_ERR_EN
    // Sticky bus error on a SLVERR response to the second store
    check("t6_bus_err_init", bus_err === 1'b0, bus_err, 1'b0);
    awready = 1'b1;
    wready  = 1'b1;
    bvalid  = 1'b1;
    bresp   = 2'b00;
    st_req  = 1'b1;
    st_addr = 32'hB00;
    cyc();
    st_req = 1'b0;
    repeat (3) cyc();
    check("t6_s1_empty", buf_empty === 1'b1, buf_empty, 1'b1);
    check("t6_s1_no_err", bus_err === 1'b0, bus_err, 1'b0);
    bresp   = 2'b10;
    st_req  = 1'b1;
    st_addr = 32'hB04;
    cyc();
    st_req = 1'b0;
    repeat (2) cyc();
    check("t6_s2_resp", bready === 1'b1, bready, 1'b1);
    check("t6_s2_before_b", bus_err === 1'b0, bus_err, 1'b0);
    cyc();
    bresp = 2'b00;
    #1;
    check("t6_s2_err_set", bus_err === 1'b1, bus_err, 1'b1);
    check("t6_s2_popped", buf_empty === 1'b1, buf_empty, 1'b1);
    st_req  = 1'b1;
    st_addr = 32'hB08;
    cyc();
    st_req = 1'b0;
    repeat (3) cyc();
    check("t6_s3_drained", buf_empty === 1'b1, buf_empty, 1'b1);
    check("t6_err_sticky", bus_err === 1'b1, bus_err, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
